// File: rtl/output_fifo_if.sv
// Handshake bundle between the last pipeline stage, output_fifo and the downstream consumer.
//   valid_in/data_in   : beat from the pipeline
//   fifo_out_ready     : backpressure back to the pipeline
//   data_out/valid_out : first-word-fall-through head to the consumer
//   ready_in           : consumer accepts head this cycle
//   count/overflow     : occupancy and sticky lost-beat flag
// slave is the FIFO side; master is the environment (pipeline + consumer) side.
interface output_fifo_if #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned DEPTH     = 16
);
  localparam int unsigned CountW = $clog2(DEPTH + 1);

  logic                 valid_in;
  logic [DATA_SIZE-1:0] data_in;
  logic                 fifo_out_ready;
  logic [DATA_SIZE-1:0] data_out;
  logic                 valid_out;
  logic                 ready_in;
  logic [CountW-1:0]    count;
  logic                 overflow;

  modport slave (
    input  valid_in, data_in, ready_in,
    output fifo_out_ready, data_out, valid_out, count, overflow
  );

  modport master (
    output valid_in, data_in, ready_in,
    input  fifo_out_ready, data_out, valid_out, count, overflow
  );
endinterface

// File: rtl/output_fifo.sv
// Circular output FIFO closing the pipeline's fifo_out_ready loop.
// Accepts beats from the last pipeline stage, stores them, and presents them to the consumer on a
// first-word-fall-through valid/ready port.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; clears pointers, count and overflow
//   bus   : output_fifo_if.slave (valid_in, data_in, fifo_out_ready, data_out, valid_out,
//           ready_in, count, overflow)
// DEPTH must be a power of two >= 4; SKID (0..DEPTH-2) entries stay free after fifo_out_ready
// drops to absorb beats already in flight.
module output_fifo #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned SKID      = 1
) (
  input logic            clk,
  input logic            reset,
  output_fifo_if.slave   bus
);
  localparam int unsigned AddrW  = $clog2(DEPTH);
  localparam int unsigned CountW = $clog2(DEPTH + 1);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [AddrW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CountW-1:0]    count_q;
  logic                 overflow_q;

  logic full, pop, push, valid_out;

  assign full      = (count_q == CountW'(DEPTH));
  assign valid_out = (count_q != '0);
  assign pop       = valid_out & bus.ready_in;
  // A pop frees a slot in the same cycle, so a full FIFO still takes a beat when draining.
  assign push      = bus.valid_in & (~full | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AddrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CountW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CountW'(1);
      end
      if (bus.valid_in && full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage is deliberately not reset; valid_out masks stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.data_in;
    end
  end

  // Derived only from registered count so the pipeline loop has no combinational path.
  assign bus.fifo_out_ready = (count_q < CountW'(DEPTH - SKID));
  assign bus.valid_out      = valid_out;
  assign bus.data_out       = mem[rd_ptr_q];
  assign bus.count          = count_q;
  assign bus.overflow       = overflow_q;
endmodule
